// File: rtl/score_lives_display_if.sv
// Game I/O bundle: score/collision taps in, score, lives and 7-seg pins out.
// master drives the taps, slave is the score/lives/display block.
interface score_lives_display_if #(
  parameter int NUM_DIGITS = 4,
  parameter int MAX_LIVES  = 3
);
  logic                    score_tick;
  logic                    collision;
  logic                    restart;
  logic                    paused;
  logic [4*NUM_DIGITS-1:0] score_bcd;
  logic [3:0]              lives;
  logic [MAX_LIVES-1:0]    lives_led;
  logic                    game_over;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   anode;

  modport master (
    output score_tick,
    output collision,
    output restart,
    output paused,
    input  score_bcd,
    input  lives,
    input  lives_led,
    input  game_over,
    input  seg,
    input  anode
  );

  modport slave (
    input  score_tick,
    input  collision,
    input  restart,
    input  paused,
    output score_bcd,
    output lives,
    output lives_led,
    output game_over,
    output seg,
    output anode
  );
endinterface

// File: rtl/score_lives_display.sv
// N-digit BCD score, lives counter and multiplexed 7-seg driver.
// Define HIGH_SCORE_EN to add a high-score register shown while paused.
module score_lives_display #(
  parameter int NUM_DIGITS  = 4,
  parameter int SCAN_DIV    = 100000,
  parameter int MAX_LIVES   = 3,
  parameter int SEG_ACT_LOW = 1
) (
  input logic                  clk,
  input logic                  reset,
  score_lives_display_if.slave io
);

  localparam int SW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam bit LOW = (SEG_ACT_LOW != 0);
  localparam logic [SW-1:0] ALL9 = {NUM_DIGITS{4'h9}};
  localparam logic [3:0] LIVES0 = 4'(MAX_LIVES);
  localparam logic [6:0] SEG_OFF = LOW ? 7'h7f : 7'h00;
  localparam logic [NUM_DIGITS-1:0] AN_OFF =
    LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] p;
    unique case (d)
      4'd0:    p = 7'b1111110;
      4'd1:    p = 7'b0110000;
      4'd2:    p = 7'b1101101;
      4'd3:    p = 7'b1111001;
      4'd4:    p = 7'b0110011;
      4'd5:    p = 7'b1011011;
      4'd6:    p = 7'b1011111;
      4'd7:    p = 7'b1110000;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1111011;
      default: p = 7'b0000000;
    endcase
    return p;
  endfunction

  logic                  tick_cur_q, tick_prev_q;
  logic                  coll_cur_q, coll_prev_q;
  logic [SW-1:0]         score_q, score_d;
  logic [3:0]            lives_q, lives_d;
  logic [CW-1:0]         scan_q, scan_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] anode_q, anode_d;

  logic                  tick_ev, coll_ev, game_over;
  logic [SW-1:0]         score_inc;
  logic                  carry;
  logic                  scan_wrap;
  logic [SW-1:0]         disp;
  logic [NUM_DIGITS-1:0] keep, an_on;
  logic                  seen;
  logic [3:0]            cur_dig;
  logic                  cur_show;
  logic [6:0]            pat;
  logic [MAX_LIVES-1:0]  led;

`ifdef HIGH_SCORE_EN
  logic [SW-1:0]         hs_q, hs_d;
  logic                  go_prev_q;
`endif

  always_comb begin
    tick_ev   = tick_cur_q & ~tick_prev_q;
    coll_ev   = coll_cur_q & ~coll_prev_q;
    game_over = (lives_q == 4'd0);

    score_inc = score_q;
    carry     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (score_q[4*i +: 4] == 4'd9) begin
          score_inc[4*i +: 4] = 4'd0;
        end else begin
          score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
    end

    // score sees game_over from before any same-cycle life loss
    score_d = score_q;
    lives_d = lives_q;
    if (io.restart) begin
      score_d = '0;
      lives_d = LIVES0;
    end else if (!io.paused) begin
      if (tick_ev && !game_over && score_q != ALL9)
        score_d = score_inc;
      if (coll_ev && !game_over)
        lives_d = lives_q - 4'd1;
    end
  end

`ifdef HIGH_SCORE_EN
  always_comb begin
    hs_d = hs_q;
    if (game_over && !go_prev_q && score_q > hs_q)
      hs_d = score_q;
  end
`endif

  always_comb begin
    scan_wrap = (scan_q == CW'(SCAN_DIV - 1));
    scan_d    = scan_wrap ? '0 : scan_q + CW'(1);
    idx_d     = idx_q;
    if (scan_wrap)
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
  end

  always_comb begin
`ifdef HIGH_SCORE_EN
    disp = io.paused ? hs_q : score_q;
`else
    disp = score_q;
`endif
    // keep[i]: digit i is at or below the top non-zero digit
    seen = 1'b0;
    keep = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      seen    = seen | (disp[4*i +: 4] != 4'd0) | (i == 0);
      keep[i] = seen;
    end

    cur_dig  = 4'd0;
    cur_show = 1'b0;
    an_on    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_dig  = disp[4*i +: 4];
        cur_show = keep[i];
        an_on[i] = 1'b1;
      end
    end

    pat     = dec7(cur_dig);
    seg_d   = cur_show ? (LOW ? ~pat : pat) : SEG_OFF;
    anode_d = LOW ? ~an_on : an_on;
  end

  always_comb begin
    led = '0;
    for (int i = 0; i < MAX_LIVES; i++)
      led[i] = (lives_q > 4'(i));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cur_q  <= 1'b0;
      tick_prev_q <= 1'b0;
      coll_cur_q  <= 1'b0;
      coll_prev_q <= 1'b0;
      score_q     <= '0;
      lives_q     <= LIVES0;
      scan_q      <= '0;
      idx_q       <= '0;
      seg_q       <= SEG_OFF;
      anode_q     <= AN_OFF;
    end else begin
      tick_cur_q  <= io.score_tick;
      tick_prev_q <= tick_cur_q;
      coll_cur_q  <= io.collision;
      coll_prev_q <= coll_cur_q;
      score_q     <= score_d;
      lives_q     <= lives_d;
      scan_q      <= scan_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      anode_q     <= anode_d;
    end
  end

`ifdef HIGH_SCORE_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs_q      <= '0;
      go_prev_q <= 1'b0;
    end else begin
      hs_q      <= hs_d;
      go_prev_q <= game_over;
    end
  end
`endif

  assign io.score_bcd = score_q;
  assign io.lives     = lives_q;
  assign io.lives_led = led;
  assign io.game_over = game_over;
  assign io.seg       = seg_q;
  assign io.anode     = anode_q;

endmodule

// File: tb/tb_score_lives_display.sv
// Scoreboard bench for score_lives_display (4 digits, 3 lives, active-low).
// Stimulus queues expected states; monitors compare on each output change.
module tb_score_lives_display;

  localparam int ND = 4;
  localparam int ML = 3;
  localparam int SD = 4;

  typedef struct packed {
    logic [15:0] score;
    logic [3:0]  lives;
    logic        go;
    logic [2:0]  led;
  } st_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } dp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   mon_en = 1'b0;
  bit   d_arm = 1'b0;
  bit   d_start = 1'b0;
  int   dwell = 0;
  st_t  exp_q[$];
  dp_t  dq[$];
  st_t  last;
  logic [3:0] last_an;

  score_lives_display_if #(.NUM_DIGITS(ND), .MAX_LIVES(ML)) io ();

  score_lives_display #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD),
    .MAX_LIVES(ML), .SEG_ACT_LOW(1)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .io(io)
  );

  always #5 clk = ~clk;

  function automatic st_t mk(logic [15:0] s, logic [3:0] l);
    st_t r;
    r.score = s;
    r.lives = l;
    r.go    = (l == 4'd0);
    r.led   = (l >= 4'd3) ? 3'b111 : (l == 4'd2) ? 3'b011 :
              (l == 4'd1) ? 3'b001 : 3'b000;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    logic [15:0] r;
    int t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic dp_t dp(logic [3:0] an, logic [6:0] sg);
    dp_t r;
    r.an  = an;
    r.seg = sg;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    st_t cur, e;
    if (mon_en) begin
      cur.score = io.score_bcd;
      cur.lives = io.lives;
      cur.go    = io.game_over;
      cur.led   = io.lives_led;
      if (cur !== last) begin
        last = cur;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_change actual score=%h lives=%0d required no change",
                   cur.score, cur.lives);
        end else begin
          e = exp_q.pop_front();
          chk("score_bcd", 32'(cur.score), 32'(e.score));
          chk("lives", 32'(cur.lives), 32'(e.lives));
          chk("game_over", 32'(cur.go), 32'(e.go));
          chk("lives_led", 32'(cur.led), 32'(e.led));
        end
      end
    end
  end

  always @(negedge clk) begin
    dp_t e;
    dwell++;
    if (io.anode !== last_an) begin
      last_an = io.anode;
      if (d_arm && dq.size() > 0) begin
        if (!d_start && io.anode === dq[0].an) begin
          d_start = 1'b1;
          e = dq.pop_front();
          chk("seg_first", 32'(io.seg), 32'(e.seg));
        end else if (d_start) begin
          e = dq.pop_front();
          chk("anode", 32'(io.anode), 32'(e.an));
          chk("seg", 32'(io.seg), 32'(e.seg));
          chk("scan_dwell", 32'(dwell), 32'(SD));
        end
      end
      dwell = 0;
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(bit t, bit c, bit r);
    io.score_tick = t;
    io.collision  = c;
    io.restart    = r;
    cyc(1);
    io.score_tick = 1'b0;
    io.collision  = 1'b0;
    io.restart    = 1'b0;
    cyc(1);
  endtask

  task automatic wait_sb(string nm);
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) cyc(1);
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual pending=%0d required 0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_disp(string nm);
    d_arm = 1'b1;
    for (int i = 0; i < 200 && dq.size() > 0; i++) cyc(1);
    if (dq.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual pending=%0d required 0", nm, dq.size());
      dq.delete();
    end
    d_arm   = 1'b0;
    d_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    io.score_tick = 1'b0;
    io.collision  = 1'b0;
    io.restart    = 1'b0;
    io.paused     = 1'b0;
    exp_q.push_back(mk(16'h0000, 4'd3));
    mon_en = 1'b1;
    cyc(3);
    chk("rst_anode", 32'(io.anode), 32'h0f);
    chk("rst_seg", 32'(io.seg), 32'h7f);
    rst_n = 1'b1;
    cyc(2);
    wait_sb("reset");

    // score 0 shows "0" with upper digits blank
    dq.push_back(dp(4'b1110, 7'b0000001));
    dq.push_back(dp(4'b1101, 7'b1111111));
    dq.push_back(dp(4'b1011, 7'b1111111));
    dq.push_back(dp(4'b0111, 7'b1111111));
    dq.push_back(dp(4'b1110, 7'b0000001));
    wait_disp("disp_zero");

    exp_q.push_back(mk(16'h0001, 4'd3));
    io.score_tick = 1'b1;
    cyc(50);
    io.score_tick = 1'b0;
    cyc(2);
    wait_sb("held_tick");

    for (int v = 2; v <= 1233; v++) begin
      exp_q.push_back(mk(to_bcd(v), 4'd3));
      pulse(1, 0, 0);
    end
    exp_q.push_back(mk(16'h1234, 4'd3));
    pulse(1, 0, 0);
    wait_sb("count_1234");

    dq.push_back(dp(4'b1110, 7'b1001100));
    dq.push_back(dp(4'b1101, 7'b0000110));
    dq.push_back(dp(4'b1011, 7'b0010010));
    dq.push_back(dp(4'b0111, 7'b1001111));
    dq.push_back(dp(4'b1110, 7'b1001100));
    wait_disp("disp_1234");

    exp_q.push_back(mk(16'h0000, 4'd3));
    pulse(0, 0, 1);
    wait_sb("restart1");

    io.paused = 1'b1;
    pulse(1, 1, 0);
    cyc(3);
    io.paused = 1'b0;
    cyc(2);

    for (int v = 1; v <= 998; v++) begin
      exp_q.push_back(mk(to_bcd(v), 4'd3));
      pulse(1, 0, 0);
    end
    exp_q.push_back(mk(16'h0999, 4'd3));
    pulse(1, 0, 0);
    exp_q.push_back(mk(16'h1000, 4'd3));
    pulse(1, 0, 0);
    wait_sb("carry_1000");
    for (int v = 1001; v <= 9998; v++) begin
      exp_q.push_back(mk(to_bcd(v), 4'd3));
      pulse(1, 0, 0);
    end
    exp_q.push_back(mk(16'h9999, 4'd3));
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    cyc(4);
    wait_sb("saturate");

    exp_q.push_back(mk(16'h0000, 4'd3));
    pulse(0, 0, 1);
    exp_q.push_back(mk(16'h0000, 4'd2));
    pulse(0, 1, 0);
    exp_q.push_back(mk(16'h0000, 4'd1));
    pulse(0, 1, 0);
    exp_q.push_back(mk(16'h0001, 4'd0));
    pulse(1, 1, 0);
    cyc(1);
    pulse(1, 0, 0);
    pulse(0, 1, 0);
    cyc(3);
    wait_sb("game_over");
    exp_q.push_back(mk(16'h0000, 4'd3));
    pulse(0, 0, 1);
    wait_sb("restart2");

`ifdef HIGH_SCORE_EN
    for (int v = 1; v <= 41; v++) begin
      exp_q.push_back(mk(to_bcd(v), 4'd3));
      pulse(1, 0, 0);
    end
    exp_q.push_back(mk(16'h0042, 4'd3));
    pulse(1, 0, 0);
    exp_q.push_back(mk(16'h0042, 4'd2));
    pulse(0, 1, 0);
    exp_q.push_back(mk(16'h0042, 4'd1));
    pulse(0, 1, 0);
    exp_q.push_back(mk(16'h0042, 4'd0));
    pulse(0, 1, 0);
    cyc(2);
    exp_q.push_back(mk(16'h0000, 4'd3));
    pulse(0, 0, 1);
    wait_sb("hs_game");
    io.paused = 1'b1;
    dq.push_back(dp(4'b1110, 7'b0010010));
    dq.push_back(dp(4'b1101, 7'b1001100));
    dq.push_back(dp(4'b1011, 7'b1111111));
    dq.push_back(dp(4'b0111, 7'b1111111));
    dq.push_back(dp(4'b1110, 7'b0010010));
    wait_disp("disp_hs");
    chk("hs_score_bcd", 32'(io.score_bcd), 32'h0000);
    io.paused = 1'b0;
    cyc(2);
`endif

    exp_q.push_back(mk(16'h0001, 4'd3));
    pulse(1, 0, 0);
    cyc(2);
    wait_sb("pre_reset");
    exp_q.push_back(mk(16'h0000, 4'd3));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_anode", 32'(io.anode), 32'h0f);
    chk("midrst_seg", 32'(io.seg), 32'h7f);
    chk("midrst_score", 32'(io.score_bcd), 32'h0000);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    wait_sb("mid_reset");

    cyc(5);
    chk("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
